// File: rtl/bitplane_accum_pkg.sv
// Shared types and sizing for the bit-plane accumulator slice.
package calc_pkg;
  localparam int N_ENG  = 8;
  localparam int N_LANE = 4;
  localparam int PW     = 17;
  localparam int NPLANE = 5;
  localparam int AW     = 24;
  localparam int PLW    = 3;

  typedef logic signed [PW-1:0] partial_t;
  typedef logic signed [AW-1:0] acc_t;
  typedef logic [PLW-1:0]       plane_t;

  typedef enum logic {WAIT0 = 1'b0, ACC = 1'b1} state_e;
endpackage

// File: rtl/bitplane_accum_if.sv
// Slice input and result output bundle between the engine array and writeback.
interface bitplane_accum_if;
  import calc_pkg::*;

  logic                                  in_valid;
  logic [N_ENG-1:0][PLW-1:0]             in_plane;
  logic [N_ENG-1:0][N_LANE-1:0][PW-1:0]  in_partial;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [N_ENG-1:0][N_LANE-1:0][AW-1:0]  out_data;

  modport master (output in_valid, in_plane, in_partial, out_ready,
                  input  out_valid, out_data);
  modport slave  (input  in_valid, in_plane, in_partial, out_ready,
                  output out_valid, out_data);
endinterface

// File: rtl/bitplane_accum_lane.sv
// One lane: sign-extend, scale by 2^plane, optionally negate the sign plane, accumulate.
module accum_lane
  import calc_pkg::*;
#(
  parameter bit SIGNED_W = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  logic     add,
  input  plane_t   plane,
  input  partial_t partial,
  output acc_t     acc
);
  acc_t acc_q, acc_d, ext, shl, term;

  always_comb begin
    ext   = acc_t'(partial);
    shl   = ext <<< plane;
    term  = (SIGNED_W && plane == plane_t'(NPLANE-1)) ? -shl : shl;
    acc_d = acc_q;
    if (load)     acc_d = term;
    else if (add) acc_d = acc_q + term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  // Exposes the value including this cycle's term so a completion can be
  // captured by the output buffer on the same edge.
  assign acc = acc_d;
endmodule

// File: rtl/bitplane_accum.sv
// Plane-sequencing FSM, per-lane accumulators, single-entry result buffer, sticky errors.
module bitplane_accum
  import calc_pkg::*;
#(
  parameter bit SIGNED_W = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  bitplane_accum_if.slave  bus,
  output logic             seq_err,
  output logic             ovr_err,
  input  logic             err_clr
);
  state_e state_q, state_d;
  plane_t exp_q, exp_d, plane0;
  logic   load, add, done, seq_set, ovr_set;
  logic   out_valid_q, out_valid_d, seq_err_q, seq_err_d, ovr_err_q, ovr_err_d;
  logic [N_ENG-1:0][N_LANE-1:0][AW-1:0] acc_w, out_data_q, out_data_d;

  assign plane0 = bus.in_plane[0];

  for (genvar e = 0; e < N_ENG; e++) begin : g_eng
    for (genvar l = 0; l < N_LANE; l++) begin : g_lane
      accum_lane #(.SIGNED_W(SIGNED_W)) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .add    (add),
        .plane  (plane0),
        .partial(bus.in_partial[e][l]),
        .acc    (acc_w[e][l])
      );
    end
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    load    = 1'b0;
    add     = 1'b0;
    done    = 1'b0;
    seq_set = 1'b0;
    if (bus.in_valid) begin
      // Engine 0 is authoritative; disagreement is only flagged.
      for (int j = 1; j < N_ENG; j++)
        if (bus.in_plane[j] != plane0) seq_set = 1'b1;
      unique case (state_q)
        WAIT0: begin
          if (plane0 == '0) begin
            load = 1'b1; exp_d = plane_t'(1); state_d = ACC;
          end else seq_set = 1'b1;
        end
        ACC: begin
          if (plane0 == exp_q) begin
            add = 1'b1;
            if (exp_q == plane_t'(NPLANE-1)) begin
              done = 1'b1; exp_d = '0; state_d = WAIT0;
            end else exp_d = plane_t'(exp_q + 3'd1);
          end else if (plane0 == '0) begin
            seq_set = 1'b1; load = 1'b1; exp_d = plane_t'(1);
          end else begin
            seq_set = 1'b1; exp_d = '0; state_d = WAIT0;
          end
        end
        default: state_d = WAIT0;
      endcase
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ovr_set     = 1'b0;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (done) begin
      if (!out_valid_q || bus.out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = acc_w;
      end else ovr_set = 1'b1;
    end
    // A same-cycle set beats the clear.
    seq_err_d = seq_set | (seq_err_q & ~err_clr);
    ovr_err_d = ovr_set | (ovr_err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT0;
      exp_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      seq_err_q   <= 1'b0;
      ovr_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      seq_err_q   <= seq_err_d;
      ovr_err_q   <= ovr_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign seq_err       = seq_err_q;
  assign ovr_err       = ovr_err_q;
endmodule

// File: tb/tb_bitplane_accum.sv
// Scoreboard bench: two DUTs (unsigned and signed weight) fed identical slices.
module tb_bitplane_accum;
  import calc_pkg::*;
  typedef logic [N_ENG-1:0][N_LANE-1:0][AW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst_n, err_clr;
  logic seq_err0, ovr_err0, seq_err1, ovr_err1;
  logic d_valid, d_ready;
  logic [N_ENG-1:0][PLW-1:0]            d_plane;
  logic [N_ENG-1:0][N_LANE-1:0][PW-1:0] d_part;

  always #5 clk = ~clk;

  bitplane_accum_if if0();
  bitplane_accum_if if1();
  assign if0.in_valid = d_valid; assign if0.in_plane = d_plane;
  assign if0.in_partial = d_part; assign if0.out_ready = d_ready;
  assign if1.in_valid = d_valid; assign if1.in_plane = d_plane;
  assign if1.in_partial = d_part; assign if1.out_ready = d_ready;

  bitplane_accum #(.SIGNED_W(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0),
    .seq_err(seq_err0), .ovr_err(ovr_err0), .err_clr(err_clr));
  bitplane_accum #(.SIGNED_W(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1),
    .seq_err(seq_err1), .ovr_err(ovr_err1), .err_clr(err_clr));

  // Reference model: nxt is the next plane expected (0 = waiting for a fresh word).
  int     nxt;
  bit     mvalid, mseq, movr;
  longint macc [2][N_ENG*N_LANE];
  vec_t   q0[$], q1[$];
  int     tests = 0, fails = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    nxt = 0; mvalid = 0; mseq = 0; movr = 0;
    q0.delete(); q1.delete();
  endtask

  task automatic add_terms(int p, bit restart);
    longint v, w;
    for (int c = 0; c < 2; c++)
      for (int e = 0; e < N_ENG; e++)
        for (int l = 0; l < N_LANE; l++) begin
          v = longint'($signed(d_part[e][l]));
          w = longint'(1) << p;
          if (c == 1 && p == NPLANE-1) w = -w;
          if (restart) macc[c][e*N_LANE+l] = v * w;
          else         macc[c][e*N_LANE+l] = macc[c][e*N_LANE+l] + v * w;
        end
  endtask

  function automatic vec_t pack(int c);
    vec_t v;
    for (int e = 0; e < N_ENG; e++)
      for (int l = 0; l < N_LANE; l++) v[e][l] = macc[c][e*N_LANE+l][AW-1:0];
    return v;
  endfunction

  task automatic model_eval();
    int p; bit seq, done, ovr, nv;
    seq = 0; done = 0; ovr = 0;
    if (d_valid) begin
      p = int'(d_plane[0]);
      for (int j = 1; j < N_ENG; j++) if (d_plane[j] != d_plane[0]) seq = 1;
      if (p == 0) begin
        if (nxt != 0) seq = 1;
        add_terms(p, 1); nxt = 1;
      end else if (p == nxt) begin
        add_terms(p, 0);
        if (nxt == NPLANE-1) begin done = 1; nxt = 0; end
        else nxt++;
      end else begin
        seq = 1; nxt = 0;
      end
    end
    nv = mvalid && !d_ready;
    if (done) begin
      if (!mvalid || d_ready) begin
        q0.push_back(pack(0)); q1.push_back(pack(1)); nv = 1;
      end else ovr = 1;
    end
    mvalid = nv;
    mseq = seq | (mseq & !err_clr);
    movr = ovr | (movr & !err_clr);
  endtask

  task automatic check_dut(int c, logic ov, vec_t od, logic se, logic oe);
    vec_t e;
    chk($sformatf("out_valid c%0d", c), 32'(ov), 32'(mvalid));
    chk($sformatf("seq_err c%0d", c), 32'(se), 32'(mseq));
    chk($sformatf("ovr_err c%0d", c), 32'(oe), 32'(movr));
    if (ov && d_ready) begin
      tests++;
      if ((c == 0 ? q0.size() : q1.size()) == 0) begin
        fails++;
        $display("FAIL data c%0d: got unexpected result %h, expected none", c, od);
      end else begin
        if (c == 0) e = q0.pop_front(); else e = q1.pop_front();
        if (od !== e) begin
          fails++;
          $display("FAIL data c%0d: got %h expected %h", c, od, e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    check_dut(0, if0.out_valid, if0.out_data, seq_err0, ovr_err0);
    check_dut(1, if1.out_valid, if1.out_data, seq_err1, ovr_err1);
  end

  task automatic tick();
    @(posedge clk);
    model_eval();
    #1;
  endtask

  task automatic set_plane(int p);
    for (int e = 0; e < N_ENG; e++) d_plane[e] = PLW'(p);
  endtask

  task automatic send(int p, int pv);
    d_valid = 1; set_plane(p);
    for (int e = 0; e < N_ENG; e++)
      for (int l = 0; l < N_LANE; l++) d_part[e][l] = PW'(pv);
    tick();
  endtask

  task automatic send_rand(int p);
    d_valid = 1; set_plane(p);
    for (int e = 0; e < N_ENG; e++)
      for (int l = 0; l < N_LANE; l++) d_part[e][l] = PW'($urandom);
    tick();
  endtask

  task automatic idle();
    d_valid = 0; tick();
  endtask

  task automatic pulse_clr();
    err_clr = 1; idle(); err_clr = 0;
  endtask

  task automatic expect_all(int c, logic [AW-1:0] v, string nm);
    vec_t od;
    bit ok;
    od = (c == 0) ? if0.out_data : if1.out_data;
    ok = ((c == 0) ? if0.out_valid : if1.out_valid) === 1'b1;
    for (int e = 0; e < N_ENG; e++)
      for (int l = 0; l < N_LANE; l++) if (od[e][l] !== v) ok = 0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s c%0d: got %h expected all entries %h", nm, c, od, v);
    end
  endtask

  task automatic check_reset_state(string nm);
    chk({nm, " out_valid0"}, 32'(if0.out_valid), 0);
    chk({nm, " out_valid1"}, 32'(if1.out_valid), 0);
    chk({nm, " data0_zero"}, 32'(if0.out_data != '0), 0);
    chk({nm, " data1_zero"}, 32'(if1.out_data != '0), 0);
    chk({nm, " errs"}, 32'({seq_err0, ovr_err0, seq_err1, ovr_err1}), 0);
  endtask

  initial begin
    int rp, p;
    rst_n = 0; err_clr = 0; d_valid = 0; d_ready = 1; d_plane = '0; d_part = '0;
    model_reset();
    #12 check_reset_state("reset");
    #10 rst_n = 1;

    // Weight 0b00101 with partial 100 → 100 + 400.
    send(0, 100); send(1, 0); send(2, 100); send(3, 0); send(4, 0);
    expect_all(0, 24'd500, "w00101"); expect_all(1, 24'd500, "w00101");
    idle();
    // Weight -1 pattern: 3*(1+2+4+8-16) signed, 3*31 unsigned.
    for (int i = 0; i < NPLANE; i++) send(i, 3);
    expect_all(0, 24'd93, "ones"); expect_all(1, 24'hFFFFFD, "ones");
    // -65536*31 = 0xE10000 mod 2^24; signed: -65536*(15-16) = 0x010000.
    for (int i = 0; i < NPLANE; i++) send(i, -65536);
    expect_all(0, 24'hE10000, "minpart"); expect_all(1, 24'h010000, "minpart");
    idle();

    // Overrun: two words with no ready; first held, second dropped.
    d_ready = 0;
    for (int k = 0; k < 2; k++) for (int i = 0; i < NPLANE; i++) send_rand(i);
    chk("ovr_set", 32'(ovr_err0), 1);
    idle();
    d_ready = 1; idle(); d_ready = 0; idle();
    chk("drop_valid", 32'(if0.out_valid), 0);
    pulse_clr();
    chk("ovr_clr", 32'(ovr_err0), 0);
    d_ready = 1;

    // Out-of-order plane, then recovery.
    send_rand(0); send_rand(1); send_rand(3);
    chk("skip_seq", 32'(seq_err1), 1);
    for (int i = 0; i < NPLANE; i++) send_rand(i);
    idle();
    pulse_clr();
    chk("seq_clr", 32'(seq_err0), 0);

    // Engine disagreement: engine 5 says 2 while engine 0 says 1.
    send_rand(0);
    d_valid = 1; set_plane(1); d_plane[5] = 3'd2; tick();
    chk("eng_mismatch", 32'(seq_err0), 1);
    for (int i = 2; i < NPLANE; i++) send_rand(i);
    idle(); pulse_clr();

    // Reset in the middle of a word.
    send_rand(0); send_rand(1); send_rand(2);
    rst_n = 0; model_reset();
    #2 check_reset_state("midreset");
    #4 rst_n = 1;
    for (int i = 0; i < NPLANE; i++) send_rand(i);
    idle();

    // Random traffic with occasional misordering and mismatched engines.
    rp = 0;
    for (int i = 0; i < 400; i++) begin
      d_valid = ($urandom_range(0, 99) < 85);
      p = rp;
      if ($urandom_range(0, 99) < 5) p = int'($urandom_range(0, 7));
      set_plane(p);
      if ($urandom_range(0, 99) < 5) d_plane[$urandom_range(1, N_ENG-1)] = PLW'($urandom);
      for (int e = 0; e < N_ENG; e++)
        for (int l = 0; l < N_LANE; l++) d_part[e][l] = PW'($urandom);
      d_ready = ($urandom_range(0, 99) < 70);
      err_clr = ($urandom_range(0, 99) < 4);
      tick();
      if (d_valid) rp = (rp + 1) % NPLANE;
    end
    err_clr = 0; d_ready = 1;
    idle(); idle(); idle();
    chk("drain_q0", 32'(q0.size()), 0);
    chk("drain_q1", 32'(q1.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
